// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and control states for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_LSH = 4'b0100;
    localparam logic [3:0] OP_RSH = 4'b0101;
    localparam logic [3:0] OP_ASH = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1011;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Places individual flag bits at their architectural positions.
    function automatic logic [4:0] pack_flags(input logic n, input logic z,
                                              input logic f, input logic l,
                                              input logic c);
        logic [4:0] flags;
        flags         = '0;
        flags[FLAG_N] = n;
        flags[FLAG_Z] = z;
        flags[FLAG_F] = f;
        flags[FLAG_L] = l;
        flags[FLAG_C] = c;
        return flags;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, WIDTH steps per product.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]        cnt_reg;
    logic                 busy_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]     mplier_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start) begin
            cnt_reg    <= CW'(WIDTH);
            busy_reg   <= 1'b1;
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
        end else if (busy_reg) begin
            if (cnt_reg != '0) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg - CW'(1);
            end else begin
                busy_reg <= 1'b0;
            end
        end
    end

    // done is a one-cycle strobe after the last step; the product is final then.
    assign done = busy_reg && (cnt_reg == '0);
    assign prod = acc_reg;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; MUL is handed to a sequential multiplier.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        inst,
    input  logic [WIDTH-1:0]  reg1,
    input  logic [WIDTH-1:0]  reg2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [4:0]        flagreg
);

    localparam int MSB = WIDTH - 1;

    state_t               state_reg, state_next;
    logic                 out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic [4:0]           flag_reg, flag_next;
    logic                 ready_c;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH-1:0]     mul_lo, mul_hi;
    logic [4:0]           mul_flags;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]       sum_w, diff_w;
    logic [SHW-1:0]       sh_amt;
    logic [2*WIDTH-1:0]   lsh_w, rsh_w, ash_w;
    logic [WIDTH-1:0]     alu_res;
    logic [4:0]           alu_flags;
    logic                 fn, fz, ff, fl, fc, known;
    logic                 sub_ovf, slt;

    assign sum_w   = {1'b0, reg1} + {1'b0, reg2};
    assign diff_w  = {1'b0, reg1} - {1'b0, reg2};
    assign sub_ovf = (reg1[MSB] != reg2[MSB]) && (diff_w[MSB] != reg1[MSB]);
    assign slt     = $signed(reg1) < $signed(reg2);
    assign sh_amt  = reg2[SHW-1:0];

    // Shifting into a double-width window leaves the last bit shifted out
    // next to the result (bit WIDTH for left, bit WIDTH-1 for right), and
    // that bit is naturally 0 for a zero amount.
    assign lsh_w = {{WIDTH{1'b0}}, reg1} << sh_amt;
    assign rsh_w = {reg1, {WIDTH{1'b0}}} >> sh_amt;
    assign ash_w = $signed({reg1, {WIDTH{1'b0}}}) >>> sh_amt;

    always_comb begin
        alu_res = '0;
        fn      = 1'b0;
        fz      = 1'b0;
        ff      = 1'b0;
        fl      = 1'b0;
        fc      = 1'b0;
        known   = 1'b1;
        case (inst)
            OP_ADD: begin
                alu_res = sum_w[MSB:0];
                fc      = sum_w[WIDTH];
                ff      = (reg1[MSB] == reg2[MSB]) && (sum_w[MSB] != reg1[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_w[MSB:0];
                fc      = diff_w[WIDTH];
                fl      = diff_w[WIDTH];
                ff      = sub_ovf;
            end
            OP_CMP: begin
                alu_res = reg1;
                fc      = diff_w[WIDTH];
                fl      = diff_w[WIDTH];
                ff      = sub_ovf;
            end
            OP_AND: alu_res = reg1 & reg2;
            OP_OR:  alu_res = reg1 | reg2;
            OP_XOR: alu_res = reg1 ^ reg2;
            OP_LSH: begin
                alu_res = lsh_w[MSB:0];
                fc      = lsh_w[WIDTH];
            end
            OP_RSH: begin
                alu_res = rsh_w[2*WIDTH-1:WIDTH];
                fc      = rsh_w[WIDTH-1];
            end
            OP_ASH: begin
                alu_res = ash_w[2*WIDTH-1:WIDTH];
                fc      = ash_w[WIDTH-1];
            end
            default: known = 1'b0;
        endcase
        if (inst == OP_CMP) begin
            fn = slt;
            fz = (reg1 == reg2);
        end else if (known) begin
            fn = alu_res[MSB];
            fz = (alu_res == '0);
        end
        alu_flags = pack_flags(fn, fz, ff, fl, fc);
    end

    // ---------------- multiplier ----------------
    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (reg1),
        .b     (reg2),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign mul_lo    = mul_prod[WIDTH-1:0];
    assign mul_hi    = mul_prod[2*WIDTH-1:WIDTH];
    assign mul_flags = pack_flags(mul_lo[MSB], mul_lo == '0, 1'b0, 1'b0, mul_hi != '0);

    // ---------------- control ----------------
    always_comb begin
        state_next     = state_reg;
        out_valid_next = out_valid_reg;
        result_next    = result_reg;
        flag_next      = flag_reg;
        ready_c        = 1'b0;
        mul_start      = 1'b0;
        case (state_reg)
            BUSY: begin
                if (mul_done) begin
                    result_next    = mul_lo;
                    flag_next      = mul_flags;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end
            // IDLE and DONE share the handshake: DONE simply always has out_valid set.
            default: begin
                ready_c = !out_valid_reg || out_ready;
                if (out_valid_reg && out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
                if (in_valid && ready_c) begin
                    if (inst == OP_MUL) begin
                        mul_start      = 1'b1;
                        out_valid_next = 1'b0;
                        state_next     = BUSY;
                    end else begin
                        result_next    = alu_res;
                        flag_next      = alu_flags;
                        out_valid_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flag_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            flag_reg      <= flag_next;
        end
    end

    assign in_ready  = ready_c;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign flagreg   = flag_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and back-pressure bench for alu_pipe at WIDTH=16.
module tb_alu_pipe;

    localparam logic [3:0] T_ADD = 4'b0000;
    localparam logic [3:0] T_AND = 4'b0001;
    localparam logic [3:0] T_OR  = 4'b0010;
    localparam logic [3:0] T_XOR = 4'b0011;
    localparam logic [3:0] T_LSH = 4'b0100;
    localparam logic [3:0] T_RSH = 4'b0101;
    localparam logic [3:0] T_ASH = 4'b0110;
    localparam logic [3:0] T_MUL = 4'b0111;
    localparam logic [3:0] T_SUB = 4'b1000;
    localparam logic [3:0] T_CMP = 4'b1011;
    localparam int NOPS = 1000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  inst;
    logic [15:0] reg1;
    logic [15:0] reg2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flagreg;

    int n_vec;
    int n_err;

    alu_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .reg1      (reg1),
        .reg2      (reg2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flagreg   (flagreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {N,Z,F,L,C, result}; shifts are modelled bit by bit.
    function automatic logic [20:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] t;
        logic [15:0] r;
        logic n, z, f, l, c, known;
        int s;
        t = '0; r = '0; n = 0; z = 0; f = 0; l = 0; c = 0; known = 1;
        s = int'(b[3:0]);
        case (op)
            T_ADD: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[15:0];
                c = t[16];
                f = (a[15] == b[15]) && (r[15] != a[15]);
            end
            T_SUB, T_CMP: begin
                t = {1'b0, a} - {1'b0, b};
                r = (op == T_CMP) ? a : t[15:0];
                c = (a < b);
                l = (a < b);
                f = (a[15] != b[15]) && (t[15] != a[15]);
            end
            T_AND: r = a & b;
            T_OR:  r = a | b;
            T_XOR: r = a ^ b;
            T_LSH: begin
                r = a;
                for (int i = 0; i < s; i++) begin c = r[15]; r = {r[14:0], 1'b0}; end
            end
            T_RSH: begin
                r = a;
                for (int i = 0; i < s; i++) begin c = r[0]; r = {1'b0, r[15:1]}; end
            end
            T_ASH: begin
                r = a;
                for (int i = 0; i < s; i++) begin c = r[0]; r = {r[15], r[15:1]}; end
            end
            default: known = 0;
        endcase
        if (op == T_CMP) begin
            n = $signed(a) < $signed(b);
            z = (a == b);
        end else if (known) begin
            n = r[15];
            z = (r == 16'h0000);
        end
        return {n, z, f, l, c, r};
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input int exp_r, input int exp_f);
        @(negedge clk);
        in_valid  = 1'b1;
        inst      = op;
        reg1      = a;
        reg2      = b;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ov"}, 32'(out_valid), 1);
        check({tag, "_r"}, 32'(result), exp_r);
        check({tag, "_f"}, 32'(flagreg), exp_f);
    endtask

    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int exp_r, input int exp_f);
        int lat;
        int rdy;
        @(negedge clk);
        in_valid  = 1'b1;
        inst      = T_MUL;
        reg1      = a;
        reg2      = b;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        lat = 0;
        rdy = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (in_ready) rdy = 1;
        end
        check({tag, "_lat"}, 32'(lat - 1), 17);
        check({tag, "_busyrdy"}, 32'(rdy), 0);
        check({tag, "_r"}, 32'(result), exp_r);
        check({tag, "_f"}, 32'(flagreg), exp_f);
        @(negedge clk);
        check({tag, "_hold_r"}, 32'(result), exp_r);
        check({tag, "_hold_ov"}, 32'(out_valid), 1);
        check({tag, "_hold_rdy"}, 32'(in_ready), 0);
        out_ready = 1'b1;
    endtask

    initial begin
        logic [20:0] exp_v;
        logic [20:0] sb_q[$];
        int sent;
        int cyc;
        int ov_seen;

        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inst      = 4'b0000;
        reg1      = 16'h0000;
        reg2      = 16'h0000;

        repeat (3) @(negedge clk);
        check("rst_ov", 32'(out_valid), 0);
        check("rst_r", 32'(result), 0);
        check("rst_f", 32'(flagreg), 0);
        rst_n = 1'b1;
        #1 check("rst_rdy", 32'(in_ready), 1);

        run_op("add_ovf",  T_ADD, 16'h7FFF, 16'h0001, 'h8000, 'h14);
        run_op("sub_eq",   T_SUB, 16'h0005, 16'h0005, 'h0000, 'h08);
        run_op("sub_neg",  T_SUB, 16'h0003, 16'h0007, 'hFFFC, 'h13);
        run_op("cmp_sgn",  T_CMP, 16'hFFFF, 16'h0001, 'hFFFF, 'h10);
        run_op("lsh_c",    T_LSH, 16'h8001, 16'h0001, 'h0002, 'h01);
        run_op("ash_15",   T_ASH, 16'h8000, 16'h000F, 'hFFFF, 'h10);
        run_op("lsh_0",    T_LSH, 16'h1234, 16'h0000, 'h1234, 'h00);
        run_op("rsh_hi",   T_RSH, 16'h1234, 16'h0010, 'h1234, 'h00);
        run_op("rsh_c",    T_RSH, 16'h8001, 16'h0001, 'h4000, 'h01);
        run_op("and",      T_AND, 16'hF0F0, 16'h0FF0, 'h00F0, 'h00);
        run_op("or",       T_OR,  16'h8000, 16'h0001, 'h8001, 'h10);
        run_op("xor_z",    T_XOR, 16'hAAAA, 16'hAAAA, 'h0000, 'h08);
        run_op("bad_op",   4'b1111, 16'hFFFF, 16'hFFFF, 'h0000, 'h00);
        run_op("add_wrap", T_ADD, 16'hFFFF, 16'h0001, 'h0000, 'h09);
        run_op("sub_ovf",  T_SUB, 16'h8000, 16'h0001, 'h7FFF, 'h04);
        run_op("cmp_eq",   T_CMP, 16'h0042, 16'h0042, 'h0042, 'h08);

        run_mul("mul_hi", 16'h0100, 16'h0100, 'h0000, 'h09);
        run_op("after_mul", T_ADD, 16'h1234, 16'h4321, 'h5555, 'h00);
        run_mul("mul_neg", 16'h00FF, 16'h0101, 'hFFFF, 'h10);
        run_mul("mul_big", 16'hFFFF, 16'hFFFF, 'h0001, 'h01);

        // Abort a multiply part-way through with reset.
        @(negedge clk);
        in_valid = 1'b1;
        inst     = T_MUL;
        reg1     = 16'h1234;
        reg2     = 16'h0003;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mulrst_ov", 32'(out_valid), 0);
        check("mulrst_r", 32'(result), 0);
        check("mulrst_f", 32'(flagreg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mulrst_rdy", 32'(in_ready), 1);
        ov_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("mulrst_nopulse", 32'(ov_seen), 0);

        // Random single-cycle stream under random back-pressure.
        sent = 0;
        cyc  = 0;
        while ((sent < NOPS || sb_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < NOPS && $urandom_range(0, 7) != 0) begin
                in_valid = 1'b1;
                inst     = 4'($urandom_range(0, 15));
                if (inst == T_MUL) inst = T_XOR;
                reg1     = 16'($urandom);
                reg2     = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("rand_spurious", 32'(out_valid), 0);
                end else begin
                    exp_v = sb_q[0];
                    check("rand_r", 32'(result), 32'(exp_v[15:0]));
                    check("rand_f", 32'(flagreg), 32'(exp_v[20:16]));
                    if (out_ready) void'(sb_q.pop_front());
                end
                if (!out_ready) check("rand_stall_rdy", 32'(in_ready), 0);
            end
            if (in_valid && out_ready) check("rand_thru", 32'(in_ready), 1);
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_alu(inst, reg1, reg2));
                sent++;
            end
        end
        in_valid = 1'b0;
        check("rand_sent", 32'(sent), NOPS);
        check("rand_drain", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
